// File: rtl/mem_store_pkg.sv
// Shared types and defaults for the MEM-stage store unit.
package mem_store_pkg;

    localparam int MAX_WAIT_DEFAULT = 64;

    typedef logic [7:0] byte_t;

    typedef enum logic {
        IDLE,
        WRITE
    } state_e;

endpackage

// File: rtl/store_lane_formatter.sv
// Steers store data into big-endian byte lanes and builds the byte enables.
module store_lane_formatter
    import mem_store_pkg::*;
(
    input  logic        is_sb,
    input  logic [1:0]  off,
    input  logic [31:0] data,
    output byte_t       lanes [0:3],
    output logic [3:0]  byte_en
);

    always_comb begin
        lanes   = '{default: '0};
        byte_en = '0;
        for (int k = 0; k < 4; k++) begin
            if (is_sb) begin
                if (off == 2'(k)) begin
                    lanes[k]   = data[7:0];
                    byte_en[k] = 1'b1;
                end
            end else begin
                // Lane 0 carries the most-significant byte.
                lanes[k]   = data[31-8*k -: 8];
                byte_en[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_store_unit.sv
// Store unit: accepts SB/SW from MEM, drives a cache write until ack
// or timeout, flags misaligned words and counts completed stores.
module mem_store_unit
    import mem_store_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic        is_LB_SB,
    input  logic [31:0] addr,
    input  logic [31:0] rt_data,
    output logic        cache_we,
    output logic [31:0] cache_addr,
    output byte_t       cache_data_in [0:3],
    output logic [3:0]  cache_byte_en,
    input  logic        cache_ack,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_err,
    output logic [15:0] store_count
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    state_e      state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic        we_q, we_d;
    logic [31:0] caddr_q, caddr_d;
    byte_t       lanes_q [0:3];
    byte_t       lanes_d [0:3];
    logic [3:0]  be_q, be_d;
    logic        mis_q, mis_d;
    logic        berr_q, berr_d;
    logic [15:0] cnt_q, cnt_d;

    byte_t       fmt_lanes [0:3];
    logic [3:0]  fmt_be;
    logic        req_ok;
    logic        hs;

    store_lane_formatter u_fmt (
        .is_sb   (is_LB_SB),
        .off     (addr[1:0]),
        .data    (rt_data),
        .lanes   (fmt_lanes),
        .byte_en (fmt_be)
    );

    assign req_ok = is_LB_SB | (addr[1:0] == 2'b00);
    assign hs     = st_valid & (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        we_d    = we_q;
        caddr_d = caddr_q;
        lanes_d = lanes_q;
        be_d    = be_q;
        cnt_d   = cnt_q;
        mis_d   = 1'b0;
        berr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hs && req_ok) begin
                    state_d = WRITE;
                    we_d    = 1'b1;
                    caddr_d = {addr[31:2], 2'b00};
                    lanes_d = fmt_lanes;
                    be_d    = fmt_be;
                    wait_d  = '0;
                end else if (hs) begin
                    mis_d = 1'b1;
                end
            end
            WRITE: begin
                // Ack wins over a timeout landing in the same cycle.
                if (cache_ack) begin
                    state_d = IDLE;
                    we_d    = 1'b0;
                    wait_d  = '0;
                    cnt_d   = cnt_q + 16'd1;
                end else if (wait_q == WW'(MAX_WAIT - 1)) begin
                    state_d = IDLE;
                    we_d    = 1'b0;
                    wait_d  = '0;
                    berr_d  = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            wait_q  <= '0;
            we_q    <= 1'b0;
            caddr_q <= '0;
            lanes_q <= '{default: '0};
            be_q    <= '0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            we_q    <= we_d;
            caddr_q <= caddr_d;
            lanes_q <= lanes_d;
            be_q    <= be_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign st_ready      = (state_q == IDLE);
    assign stall         = (state_q == WRITE) | (hs & req_ok);
    assign cache_we      = we_q;
    assign cache_addr    = caddr_q;
    assign cache_data_in = lanes_q;
    assign cache_byte_en = be_q;
    assign misaligned    = mis_q;
    assign bus_err       = berr_q;
    assign store_count   = cnt_q;

endmodule

// File: tb/tb_mem_store_unit.sv
// Self-checking bench for mem_store_unit: directed table, random
// transactions against a byte-level model, reset and wrap sequences.
module tb_mem_store_unit;
    import mem_store_pkg::*;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic        is_LB_SB = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] rt_data = '0;
    logic        cache_we;
    logic [31:0] cache_addr;
    byte_t       cache_data_in [0:3];
    logic [3:0]  cache_byte_en;
    logic        cache_ack = 1'b0;
    logic        stall;
    logic        misaligned;
    logic        bus_err;
    logic [15:0] store_count;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = '0;

    typedef struct {
        logic        sb;
        logic [31:0] a;
        logic [31:0] d;
        int          ackcyc;
        logic [31:0] e_addr;
        logic [31:0] e_lanes;
        logic [3:0]  e_be;
        int          e_we;
        logic        e_mis;
        logic        e_berr;
    } vec_t;

    mem_store_unit #(.MAX_WAIT(MW)) dut (
        .clk           (clk),
        .rst_b         (rst_b),
        .st_valid      (st_valid),
        .st_ready      (st_ready),
        .is_LB_SB      (is_LB_SB),
        .addr          (addr),
        .rt_data       (rt_data),
        .cache_we      (cache_we),
        .cache_addr    (cache_addr),
        .cache_data_in (cache_data_in),
        .cache_byte_en (cache_byte_en),
        .cache_ack     (cache_ack),
        .stall         (stall),
        .misaligned    (misaligned),
        .bus_err       (bus_err),
        .store_count   (store_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] lanes_now();
        return {cache_data_in[0], cache_data_in[1],
                cache_data_in[2], cache_data_in[3]};
    endfunction

    // Reference: byte array built from the store rules, then packed.
    function automatic vec_t model(input logic sb, input logic [31:0] a,
                                   input logic [31:0] d, input int ackcyc);
        vec_t v;
        int   b [4];
        int   off;
        off = int'(a % 4);
        v.sb = sb; v.a = a; v.d = d; v.ackcyc = ackcyc;
        v.e_addr = a - (a % 4);
        v.e_mis = !sb && off != 0;
        v.e_be = 0;
        for (int i = 0; i < 4; i++) begin
            if (sb) begin
                b[i] = (i == off) ? int'(d % 256) : 0;
                if (i == off) v.e_be = 4'(1 << i);
            end else begin
                b[i] = int'((d >> (24 - 8 * i)) % 256);
            end
        end
        if (!sb) v.e_be = 4'hF;
        v.e_lanes = 32'(b[0] * 32'h0100_0000 + b[1] * 32'h1_0000
                        + b[2] * 32'h100 + b[3]);
        if (v.e_mis) begin
            v.e_we = 0; v.e_berr = 1'b0;
        end else if (ackcyc >= 1 && ackcyc <= MW) begin
            v.e_we = ackcyc; v.e_berr = 1'b0;
        end else begin
            v.e_we = MW; v.e_berr = 1'b1;
        end
        return v;
    endfunction

    task automatic txn(input vec_t v);
        int wc = 0;
        int mc = 0;
        int bc = 0;
        @(negedge clk);
        st_valid = 1'b1; is_LB_SB = v.sb; addr = v.a; rt_data = v.d;
        cache_ack = 1'b0;
        #1;
        chk("ready_idle", 32'(st_ready), 32'd1);
        chk("stall_req", 32'(stall),
            32'(v.sb || v.a[1:0] == 2'b00));
        @(negedge clk);
        st_valid = 1'b0;
        addr = $urandom; rt_data = $urandom; is_LB_SB = 1'($urandom);
        for (int c = 1; c <= MW + 3; c++) begin
            if (misaligned) begin
                mc++;
                chk("mis_cycle", 32'(c), 32'd1);
            end
            if (bus_err) bc++;
            if (cache_we) begin
                wc++;
                chk("cache_addr", cache_addr, v.e_addr);
                chk("lanes", lanes_now(), v.e_lanes);
                chk("byte_en", 32'(cache_byte_en), 32'(v.e_be));
                chk("stall_wr", 32'(stall), 32'd1);
                chk("ready_wr", 32'(st_ready), 32'd0);
                cache_ack = (wc == v.ackcyc);
            end else begin
                chk("stall_free", 32'(stall), 32'd0);
                cache_ack = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        cache_ack = 1'b0;
        if (v.e_we > 0 && !v.e_berr) exp_cnt = exp_cnt + 16'd1;
        chk("we_cycles", 32'(wc), 32'(v.e_we));
        chk("mis_pulses", 32'(mc), 32'(v.e_mis));
        chk("berr_pulses", 32'(bc), 32'(v.e_berr));
        chk("store_count", 32'(store_count), 32'(exp_cnt));
        chk("ready_back", 32'(st_ready), 32'd1);
    endtask

    vec_t tbl [8];
    vec_t rv;

    initial begin
        tbl[0] = '{1'b0, 32'h100, 32'hDEADBEEF, 3, 32'h100, 32'hDEADBEEF,
                   4'hF, 3, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 32'h102, 32'h123456A5, 1, 32'h100, 32'h0000A500,
                   4'b0100, 1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 32'h101, 32'h55667788, 1, 32'h100, 32'h55667788,
                   4'hF, 0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 32'h200, 32'hCAFEF00D, 0, 32'h200, 32'hCAFEF00D,
                   4'hF, 4, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 32'h204, 32'h11223344, 4, 32'h204, 32'h11223344,
                   4'hF, 4, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 32'h303, 32'hAABBCCDD, 2, 32'h300, 32'h000000DD,
                   4'b1000, 2, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 32'h000, 32'h1234567F, 5, 32'h000, 32'h7F000000,
                   4'b0001, 4, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 32'h102, 32'h0BADBEEF, 2, 32'h100, 32'h0BADBEEF,
                   4'hF, 0, 1'b1, 1'b0};

        #1;
        chk("rst_we", 32'(cache_we), 32'd0);
        chk("rst_addr", cache_addr, 32'd0);
        chk("rst_lanes", lanes_now(), 32'd0);
        chk("rst_be", 32'(cache_byte_en), 32'd0);
        chk("rst_cnt", 32'(store_count), 32'd0);
        chk("rst_mis", 32'(misaligned), 32'd0);
        chk("rst_berr", 32'(bus_err), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        chk("rst_ready", 32'(st_ready), 32'd1);

        for (int i = 0; i < 8; i++) txn(tbl[i]);

        // Reset while a write is outstanding.
        @(negedge clk);
        st_valid = 1'b1; is_LB_SB = 1'b0; addr = 32'h400;
        rt_data = 32'h01020304;
        @(negedge clk);
        st_valid = 1'b0;
        chk("pre_rst_we", 32'(cache_we), 32'd1);
        rst_b = 1'b0;
        #1;
        chk("mid_rst_we", 32'(cache_we), 32'd0);
        chk("mid_rst_addr", cache_addr, 32'd0);
        chk("mid_rst_lanes", lanes_now(), 32'd0);
        chk("mid_rst_be", 32'(cache_byte_en), 32'd0);
        chk("mid_rst_cnt", 32'(store_count), 32'd0);
        exp_cnt = '0;
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        chk("post_rst_ready", 32'(st_ready), 32'd1);
        txn(model(1'b0, 32'h404, 32'h0A0B0C0D, 2));

        for (int i = 0; i < 40; i++) begin
            rv = model(1'($urandom), $urandom, $urandom,
                       int'($urandom_range(0, MW + 1)));
            txn(rv);
        end

        // Counter wrap from 0xFFFF.
        @(negedge clk);
        force dut.cnt_q = 16'hFFFF;
        #1;
        release dut.cnt_q;
        #1;
        chk("preload_cnt", 32'(store_count), 32'h0000FFFF);
        exp_cnt = 16'hFFFF;
        txn(model(1'b0, 32'h500, 32'h99887766, 1));
        chk("wrap_cnt", 32'(store_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
